cache_2way: RTL and testbench

CACHE_2WAY -- requirements
Module: cache_2way

---
 rtl/cache_2way.sv | 129 ++++++++++++
 tb/tb_cache_2way.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cache_2way.sv
// Two-way set-associative write-back, write-allocate cache with LRU replacement
// and a LOOKUP/WB/REFILL miss engine in front of a 128-bit block memory.
module cache_2way #(
    parameter int SET_BITS = 2,
    parameter int TAG_W    = 28 - SET_BITS
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [31:0]  stall_count,
    output logic [31:0]  exec_count
);
    localparam int SETS = 1 << SET_BITS;

    typedef enum logic [1:0] {LOOKUP, WB, REFILL} state_t;

    state_t               state_q;
    logic [1:0]           valid_q [SETS];
    logic [1:0]           dirty_q [SETS];
    logic                 lru_q   [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS][2];
    logic [127:0]         data_q  [SETS][2];
    logic                 victim_q;
    logic [SET_BITS-1:0]  vidx_q;
    logic [31:0]          stall_cnt_q, exec_cnt_q;

    logic [SET_BITS-1:0]  idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           off;
    logic                 req, hit, hit_way, vict_d;
    logic [1:0]           hit_w;
    logic [127:0]         hit_line;

    assign idx = proc_addr[1+SET_BITS:2];
    assign tag = proc_addr[29:2+SET_BITS];
    assign off = proc_addr[1:0];
    assign req = proc_read | proc_write;

    always_comb begin
        for (int w = 0; w < 2; w++)
            hit_w[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    end

    assign hit      = |hit_w;
    assign hit_way  = hit_w[1];
    assign hit_line = data_q[idx][hit_way];
    assign proc_rdata = hit_line[{off, 5'b0} +: 32];
    assign proc_stall = (state_q == LOOKUP) ? (req && !hit) : 1'b1;

    // Fill empty ways lowest-first before falling back on LRU.
    assign vict_d = !valid_q[idx][0] ? 1'b0 :
                    !valid_q[idx][1] ? 1'b1 : lru_q[idx];

    assign mem_write = (state_q == WB)     && !mem_ready;
    assign mem_read  = (state_q == REFILL) && !mem_ready;
    assign mem_addr  = (state_q == WB) ? {tag_q[vidx_q][victim_q], vidx_q} : proc_addr[29:2];
    assign mem_wdata = data_q[vidx_q][victim_q];

    assign stall_count = stall_cnt_q;
    assign exec_count  = exec_cnt_q;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q     <= LOOKUP;
            victim_q    <= 1'b0;
            vidx_q      <= '0;
            stall_cnt_q <= '0;
            exec_cnt_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= 1'b0;
            end
        end else begin
            if (proc_stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            else if (req)
                exec_cnt_q <= exec_cnt_q + 32'd1;

            case (state_q)
                LOOKUP: begin
                    if (req && hit) begin
                        lru_q[idx] <= ~hit_way;
                        if (proc_write)
                            dirty_q[idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        victim_q <= vict_d;
                        vidx_q   <= idx;
                        state_q  <= (valid_q[idx][vict_d] && dirty_q[idx][vict_d]) ? WB : REFILL;
                    end
                end
                WB: begin
                    if (mem_ready)
                        state_q <= REFILL;
                end
                REFILL: begin
                    if (mem_ready) begin
                        valid_q[vidx_q][victim_q] <= 1'b1;
                        dirty_q[vidx_q][victim_q] <= 1'b0;
                        lru_q[vidx_q]             <= ~victim_q;
                        state_q                   <= LOOKUP;
                    end
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && proc_write && hit)
            data_q[idx][hit_way][{off, 5'b0} +: 32] <= proc_wdata;
        if (state_q == REFILL && mem_ready) begin
            data_q[vidx_q][victim_q] <= mem_rdata;
            tag_q[vidx_q][victim_q]  <= tag;
        end
    end
endmodule

// File: tb/tb_cache_2way.sv
// Directed bench for cache_2way: refill, write hit, LRU victim choice,
// dirty writeback ordering, reset mid-refill and performance counters.
module tb_cache_2way;
    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [31:0]  stall_count, exec_count;

    int total = 0;
    int bad   = 0;

    cache_2way #(.SET_BITS(2)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_count(stall_count), .exec_count(exec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        proc_reset_n = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0;   proc_wdata = '0;
        mem_rdata = '0;   mem_ready  = 1'b0;
        #1;
        chk("rst_stall_cnt", stall_count, 0);
        chk("rst_exec_cnt",  exec_count, 0);
        chk("rst_mem_read",  mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_stall",     proc_stall, 0);
        cyc(); cyc();
        proc_reset_n = 1'b1;

        // Cold read miss on 0x10 (tag 1, set 0)
        proc_read = 1'b1; proc_addr = 30'h10; #1;
        chk("miss_stall", proc_stall, 1);
        chk("lookup_no_mem_read", mem_read, 0);
        cyc();
        chk("refill_mem_read", mem_read, 1);
        chk("refill_mem_write", mem_write, 0);
        chk("refill_addr", mem_addr, 28'h4);
        chk("refill_stall", proc_stall, 1);
        mem_rdata = {32'h1003, 32'h1002, 32'h1001, 32'h1000}; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; #1;
        chk("after_refill_stall", proc_stall, 0);
        chk("after_refill_rdata", proc_rdata, 32'h1000);
        chk("miss_stall_cnt", stall_count, 2);
        cyc();
        proc_addr = 30'h12; #1;
        chk("rdata_off2", proc_rdata, 32'h1002);
        cyc();

        // Write hit then read back
        proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h11; proc_wdata = 32'hDEADBEEF; #1;
        chk("wr_hit_stall", proc_stall, 0);
        cyc();
        chk("wr_dirty", dut.dirty_q[0][0], 1);
        proc_write = 1'b0; proc_read = 1'b1; #1;
        chk("wr_readback", proc_rdata, 32'hDEADBEEF);
        chk("wr_readback_stall", proc_stall, 0);
        cyc();

        // Fill way 1 with tag 2
        proc_addr = 30'h20; #1;
        chk("tag2_miss", proc_stall, 1);
        cyc();
        chk("tag2_refill_addr", mem_addr, 28'h8);
        mem_rdata = {32'h2003, 32'h2002, 32'h2001, 32'h2000}; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; #1;
        chk("tag2_rdata", proc_rdata, 32'h2000);
        cyc();
        // Touch tag 1, then tag 3 must evict clean tag 2
        proc_addr = 30'h10; #1;
        chk("touch_tag1", proc_stall, 0);
        cyc();
        proc_addr = 30'h30; #1;
        chk("tag3_miss", proc_stall, 1);
        cyc();
        chk("tag3_clean_no_wb", mem_write, 0);
        chk("tag3_refill", mem_read, 1);
        chk("tag3_refill_addr", mem_addr, 28'hC);
        mem_rdata = {32'h3003, 32'h3002, 32'h3001, 32'h3000}; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; #1;
        chk("tag3_rdata", proc_rdata, 32'h3000);
        cyc();
        proc_addr = 30'h11; #1;
        chk("tag1_kept", proc_stall, 0);
        chk("tag1_kept_data", proc_rdata, 32'hDEADBEEF);
        cyc();
        proc_addr = 30'h20; #1;
        chk("tag2_evicted", proc_stall, 1);
        cyc();
        mem_rdata = {32'h2003, 32'h2002, 32'h2001, 32'h2000}; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; #1;
        chk("tag2_back", proc_rdata, 32'h2000);
        cyc();

        // Tag 4 evicts dirty tag 1 (LRU): WB then REFILL
        proc_addr = 30'h40; #1;
        chk("wb_lookup_no_write", mem_write, 0);
        cyc();
        chk("wb_mem_write", mem_write, 1);
        chk("wb_no_read", mem_read, 0);
        chk("wb_addr", mem_addr, 28'h4);
        chk("wb_data", mem_wdata, {32'h1003, 32'h1002, 32'hDEADBEEF, 32'h1000});
        cyc();
        chk("wb_wait_write", mem_write, 1);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; #1;
        chk("wb_then_read", mem_read, 1);
        chk("wb_then_no_write", mem_write, 0);
        chk("wb_refill_addr", mem_addr, 28'h10);
        mem_rdata = {32'h4003, 32'h4002, 32'h4001, 32'h4000}; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; #1;
        chk("tag4_rdata", proc_rdata, 32'h4000);
        cyc();
        chk("cnt_stall_mid", stall_count, 12);
        chk("cnt_exec_mid", exec_count, 10);

        // Reset in the middle of a refill
        proc_addr = 30'h50; #1;
        cyc();
        chk("pre_rst_mem_read", mem_read, 1);
        proc_reset_n = 1'b0; #1;
        chk("rst_drops_read", mem_read, 0);
        chk("rst_clears_cnt", stall_count, 0);
        mem_rdata = {32'h5003, 32'h5002, 32'h5001, 32'h5000}; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; proc_reset_n = 1'b1; #1;
        chk("post_rst_miss", proc_stall, 1);

        // Clean miss with 3 wait cycles followed by hits
        cyc();
        cyc(); cyc(); cyc();
        chk("wait_mem_read", mem_read, 1);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; #1;
        chk("perf_refill_stall", proc_stall, 0);
        for (int i = 0; i < 11; i++) begin
            proc_addr = 30'h50 | 30'(i % 4); #1;
            chk("perf_hit_rdata", proc_rdata, 32'h5000 + 32'(i % 4));
            cyc();
        end
        proc_read = 1'b0;
        cyc(); cyc();
        chk("perf_stall_cnt", stall_count, 5);
        chk("perf_exec_cnt", exec_count, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
